itrx_aib_phy_rx_word_align: RTL and testbench

//  RX-side word aligner for the AIB data path; pairs with the TX serializer that is built on
//  the clk-low latch/flop DDR muxing. Takes one DW-bit recovered word per clk and finds the
//  TX alignment marker bit. Assembles RATIO consecutive words into one aligned wide word.

---
 rtl/itrx_aib_phy_rx_word_align_pkg.sv | 24 ++
 rtl/itrx_aib_phy_rx_word_align_if.sv | 40 ++++
 rtl/itrx_aib_phy_rx_word_align_fsm.sv | 149 ++++++++++++++
 rtl/itrx_aib_phy_rx_word_align.sv | 88 ++++++++
 tb/tb_itrx_aib_phy_rx_word_align.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/itrx_aib_phy_rx_word_align_pkg.sv
// ----------------------------------------------------------------------------
// itrx_aib_phy_rx_word_align_pkg
// Shared definitions for the AIB RX word aligner: alignment state encoding,
// the width of the good/bad group counters, and the group-judgement helper.
// No ports.
// ----------------------------------------------------------------------------
package itrx_aib_phy_rx_word_align_pkg;

    // Good/bad group counters are 4 bits wide, so lock thresholds go up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    // A group is bad when its last word lacks the marker, or when a marker
    // already showed up earlier in the same group.
    function automatic logic group_is_bad(input logic mark, input logic early_mark);
        return !mark || early_mark;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_rx_word_align_if.sv
// ----------------------------------------------------------------------------
// itrx_aib_phy_rx_word_align_if
// Bundles the aligner's data path and status signals.
//   align_en   enable alignment (low = return to HUNT)
//   rx_din     recovered DW-bit word, one per clk
//   dout       aligned wide word, first-received word in bits [DW-1:0]
//   dout_vld   1-clk pulse, dout valid
//   locked     alignment lock status
//   align_err  1-clk pulse when lock is lost
// Modports: master = upstream driver / status consumer, slave = the aligner.
// ----------------------------------------------------------------------------
interface itrx_aib_phy_rx_word_align_if #(
    parameter int DW    = 40,
    parameter int RATIO = 4
);
    logic                  align_en;
    logic [DW-1:0]         rx_din;
    logic [DW*RATIO-1:0]   dout;
    logic                  dout_vld;
    logic                  locked;
    logic                  align_err;

    modport master (
        output align_en,
        output rx_din,
        input  dout,
        input  dout_vld,
        input  locked,
        input  align_err
    );

    modport slave (
        input  align_en,
        input  rx_din,
        output dout,
        output dout_vld,
        output locked,
        output align_err
    );
endinterface

// File: rtl/itrx_aib_phy_rx_word_align_fsm.sv
// ----------------------------------------------------------------------------
// itrx_aib_phy_rx_word_align_fsm
// Alignment control: HUNT/VERIFY/LOCKED state, group phase, good and bad
// group counters. Produces the combinational load strobe for the dout
// register and the registered locked / align_err outputs.
// Ports:
//   clk, rstn   word clock, async active-low reset
//   align_en    enable; low forces HUNT on the next clk
//   mark        marker bit of the current word
//   load        this clk completes a group that is to be output
//   locked      lock status (registered)
//   align_err   1-clk pulse when lock is lost (registered)
// ----------------------------------------------------------------------------
module itrx_aib_phy_rx_word_align_fsm
    import itrx_aib_phy_rx_word_align_pkg::*;
#(
    parameter int RATIO      = 4,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic align_en,
    input  logic mark,
    output logic load,
    output logic locked,
    output logic align_err
);

    // RATIO=1 still gets a 1-bit phase so the vector is never zero-width;
    // it simply stays at 0.
    localparam int                PH_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(RATIO - 1);
    localparam logic [CNT_W-1:0]  LOCK_TGT   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  UNLOCK_TGT = CNT_W'(UNLOCK_CNT);

    align_state_e      state_reg, state_next;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [CNT_W-1:0]  good_cnt_reg, good_cnt_next;
    logic [CNT_W-1:0]  bad_cnt_reg, bad_cnt_next;
    logic              early_reg, early_next;
    logic              locked_reg, locked_next;
    logic              align_err_reg, align_err_next;

    logic              group_end;
    logic              group_bad;
    logic [CNT_W-1:0]  good_inc;
    logic [CNT_W-1:0]  bad_inc;

    assign group_end = (phase_reg == PH_LAST);
    assign group_bad = group_is_bad(mark, early_reg);
    assign good_inc  = good_cnt_reg + CNT_W'(1);
    assign bad_inc   = bad_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_HUNT;
            phase_reg     <= '0;
            good_cnt_reg  <= '0;
            bad_cnt_reg   <= '0;
            early_reg     <= 1'b0;
            locked_reg    <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            good_cnt_reg  <= good_cnt_next;
            bad_cnt_reg   <= bad_cnt_next;
            early_reg     <= early_next;
            locked_reg    <= locked_next;
            align_err_reg <= align_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = group_end ? '0 : phase_reg + PH_W'(1);
        good_cnt_next  = good_cnt_reg;
        bad_cnt_next   = bad_cnt_reg;
        // Remember any marker seen before the last word of the group.
        early_next     = group_end ? 1'b0 : (early_reg | mark);
        align_err_next = 1'b0;
        load           = 1'b0;

        if (!align_en) begin
            // Disable wins over anything else happening this clk.
            state_next    = ST_HUNT;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
            early_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_HUNT: begin
                    early_next = 1'b0;
                    if (mark) begin
                        // The marker word closes a group: next word is phase 0,
                        // and this group already counts as the first good one.
                        phase_next    = '0;
                        good_cnt_next = CNT_W'(1);
                        bad_cnt_next  = '0;
                        state_next    = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (group_end) begin
                        if (group_bad) begin
                            state_next    = ST_HUNT;
                            good_cnt_next = '0;
                        end else begin
                            good_cnt_next = good_inc;
                            if (good_inc == LOCK_TGT) begin
                                state_next   = ST_LOCKED;
                                bad_cnt_next = '0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (group_end) begin
                        if (group_bad) begin
                            if (bad_inc == UNLOCK_TGT) begin
                                // Lock lost: the final bad group is not output.
                                state_next     = ST_HUNT;
                                align_err_next = 1'b1;
                                bad_cnt_next   = '0;
                                good_cnt_next  = '0;
                            end else begin
                                bad_cnt_next = bad_inc;
                                load         = 1'b1;
                            end
                        end else begin
                            bad_cnt_next = '0;
                            load         = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end

        locked_next = (state_next == ST_LOCKED);
    end

    assign locked    = locked_reg;
    assign align_err = align_err_reg;

endmodule

// File: rtl/itrx_aib_phy_rx_word_align.sv
// ----------------------------------------------------------------------------
// itrx_aib_phy_rx_word_align
// RX word aligner for the AIB data path. Finds the TX alignment marker bit in
// the recovered word stream, assembles RATIO words into one aligned wide word
// and reports lock status.
// Ports:
//   clk    RX word clock
//   rstn   async active-low reset
//   bus    slave side of itrx_aib_phy_rx_word_align_if
//          (align_en, rx_din in; dout, dout_vld, locked, align_err out)
// ----------------------------------------------------------------------------
module itrx_aib_phy_rx_word_align
    import itrx_aib_phy_rx_word_align_pkg::*;
#(
    parameter int DW         = 40,
    parameter int RATIO      = 4,
    parameter int MARK_BIT   = 39,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    itrx_aib_phy_rx_word_align_if.slave   bus
);

    logic                  mark;
    logic                  load;
    logic [DW*RATIO-1:0]   win;
    logic [DW*RATIO-1:0]   dout_reg;
    logic                  dout_vld_reg;

    assign mark = bus.rx_din[MARK_BIT];

    // The window seen at a group end: the RATIO-1 previously captured words
    // (oldest in the low slot) plus the current word on top.
    assign win[DW*RATIO-1 -: DW] = bus.rx_din;

    generate
        if (RATIO > 1) begin : g_hist
            logic [DW*(RATIO-1)-1:0] hist_reg;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    hist_reg <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 2; i++) begin
                        hist_reg[i*DW +: DW] <= hist_reg[(i+1)*DW +: DW];
                    end
                    hist_reg[(RATIO-2)*DW +: DW] <= bus.rx_din;
                end
            end

            assign win[DW*(RATIO-1)-1:0] = hist_reg;
        end
    endgenerate

    itrx_aib_phy_rx_word_align_fsm #(
        .RATIO      (RATIO),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_fsm (
        .clk       (clk),
        .rstn      (rstn),
        .align_en  (bus.align_en),
        .mark      (mark),
        .load      (load),
        .locked    (bus.locked),
        .align_err (bus.align_err)
    );

    // dout only changes on an output group, so it holds across VERIFY,
    // HUNT and disable periods.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
        end else begin
            dout_vld_reg <= load;
            if (load) begin
                dout_reg <= win;
            end
        end
    end

    assign bus.dout     = dout_reg;
    assign bus.dout_vld = dout_vld_reg;

endmodule

// File: tb/tb_itrx_aib_phy_rx_word_align.sv
// ----------------------------------------------------------------------------
// tb_itrx_aib_phy_rx_word_align
// Self-checking bench for the AIB RX word aligner: a RATIO=4 and a RATIO=1
// instance, a group-level reference model, a hand-derived vector table,
// directed multi-cycle sequences and randomized marker streams.
// ----------------------------------------------------------------------------
module tb_itrx_aib_phy_rx_word_align;

    localparam int DW      = 40;
    localparam int MB      = 39;
    localparam int LOCKN   = 4;
    localparam int UNLOCKN = 2;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    itrx_aib_phy_rx_word_align_if #(.DW(DW), .RATIO(4)) bus4();
    itrx_aib_phy_rx_word_align_if #(.DW(DW), .RATIO(1)) bus1();

    itrx_aib_phy_rx_word_align #(
        .DW(DW), .RATIO(4), .MARK_BIT(MB), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)
    ) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    itrx_aib_phy_rx_word_align #(
        .DW(DW), .RATIO(1), .MARK_BIT(MB), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)
    ) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int sel     = 0;       // 0 = RATIO 4 instance, 1 = RATIO 1 instance

    // Actual outputs sampled after the most recent step
    logic         a_l, a_v, a_e;
    logic [159:0] a_d;

    // Reference model: works on whole groups collected in a queue
    int           m_ratio;
    int           m_mode;
    int           m_goods;
    int           m_bads;
    logic [DW-1:0] m_grp[$];
    logic [159:0] m_dout;
    bit           e_vld, e_err, e_locked;

    typedef struct {
        bit en;
        bit mk;
        bit exp_locked;
        bit exp_vld;
        bit exp_err;
    } vec_t;

    vec_t tbl [44];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_mode  = M_HUNT;
        m_goods = 0;
        m_bads  = 0;
        m_grp.delete();
        m_dout  = '0;
        e_vld   = 1'b0;
        e_err   = 1'b0;
        e_locked = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [DW-1:0] din);
        int           nmk;
        bit           good;
        logic [159:0] grp_word;
        e_vld = 1'b0;
        e_err = 1'b0;
        if (!en) begin
            m_mode  = M_HUNT;
            m_goods = 0;
            m_bads  = 0;
            m_grp.delete();
        end else if (m_mode == M_HUNT) begin
            if (din[MB]) begin
                m_goods = 1;
                m_bads  = 0;
                m_grp.delete();
                m_mode  = (LOCKN <= 1) ? M_LOCKED : M_VERIFY;
            end
        end else begin
            m_grp.push_back(din);
            if (m_grp.size() == m_ratio) begin
                nmk      = 0;
                grp_word = '0;
                foreach (m_grp[i]) begin
                    nmk += int'(m_grp[i][MB]);
                    grp_word[i*DW +: DW] = m_grp[i];
                end
                // Exactly one marker in the group, and it sits on the last word
                good = din[MB] && (nmk == 1);
                m_grp.delete();
                if (m_mode == M_VERIFY) begin
                    if (good) begin
                        m_goods++;
                        if (m_goods == LOCKN) begin
                            m_mode = M_LOCKED;
                            m_bads = 0;
                        end
                    end else begin
                        m_mode  = M_HUNT;
                        m_goods = 0;
                    end
                end else begin
                    if (good) m_bads = 0;
                    else      m_bads++;
                    if (m_bads == UNLOCKN) begin
                        m_mode = M_HUNT;
                        e_err  = 1'b1;
                        m_bads = 0;
                    end else begin
                        e_vld  = 1'b1;
                        m_dout = grp_word;
                    end
                end
            end
        end
        e_locked = (m_mode == M_LOCKED);
    endtask

    task automatic step(input bit en, input bit mk, input logic [38:0] pl);
        logic [DW-1:0] din;
        din = {mk, pl};
        if (sel == 0) begin
            bus4.align_en = en;
            bus4.rx_din   = din;
        end else begin
            bus1.align_en = en;
            bus1.rx_din   = din;
        end
        model_step(en, din);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            a_l = bus4.locked; a_v = bus4.dout_vld; a_e = bus4.align_err; a_d = bus4.dout;
        end else begin
            a_l = bus1.locked; a_v = bus1.dout_vld; a_e = bus1.align_err; a_d = {120'b0, bus1.dout};
        end
        chk("locked", a_l, e_locked);
        chk("dout_vld", a_v, e_vld);
        chk("align_err", a_e, e_err);
        chk("dout", a_d, m_dout);
        $display("cyc=%0d dut=%0d en=%0b mk=%0b locked=%0b vld=%0b err=%0b", cyc, sel, en, mk, a_l, a_v, a_e);
        cyc++;
    endtask

    task automatic do_reset();
        bus4.align_en = 1'b0;
        bus1.align_en = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [159:0] t1_exp;
        int first_vld;
        int err_seen;

        rstn = 1'b1;
        bus4.align_en = 1'b0; bus4.rx_din = '0;
        bus1.align_en = 1'b0; bus1.rx_din = '0;
        #1 rstn = 1'b0;
        #1;
        // Reset state of both instances
        chk("rst4_locked", bus4.locked, 0);
        chk("rst4_vld", bus4.dout_vld, 0);
        chk("rst4_err", bus4.align_err, 0);
        chk("rst4_dout", bus4.dout, 0);
        chk("rst1_locked", bus1.locked, 0);
        chk("rst1_vld", bus1.dout_vld, 0);
        chk("rst1_err", bus1.align_err, 0);
        chk("rst1_dout", {120'b0, bus1.dout}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sel = 0;
        m_ratio = 4;
        model_reset();

        // Lock on marker every 4th word, then lose it with missing markers
        for (int c = 0; c < 44; c++) begin
            tbl[c].en         = 1'b1;
            tbl[c].mk         = (c % 4 == 3) && (c != 27) && (c != 35) && (c != 39);
            tbl[c].exp_locked = (c >= 15) && (c < 39);
            tbl[c].exp_vld    = (c == 19) || (c == 23) || (c == 27) || (c == 31) || (c == 35);
            tbl[c].exp_err    = (c == 39);
        end
        t1_exp = {1'b1, 39'd4, 1'b0, 39'd3, 1'b0, 39'd2, 1'b0, 39'd1};
        for (int c = 0; c < 44; c++) begin
            step(tbl[c].en, tbl[c].mk, 39'(c - 15));
            chk("tbl_locked", a_l, tbl[c].exp_locked);
            chk("tbl_vld", a_v, tbl[c].exp_vld);
            chk("tbl_err", a_e, tbl[c].exp_err);
            if (c == 19) chk("t1_first_dout", a_d, t1_exp);
        end

        // Marker stream starting at offset 2 from reset
        do_reset();
        first_vld = -1;
        for (int c = 0; c < 24; c++) begin
            step(1'b1, (c % 4 == 2), 39'($urandom));
            if (a_v && first_vld < 0) first_vld = c;
        end
        chk("t2_first_vld", 160'(first_vld), 160'(18));

        // Extra marker in VERIFY, then disable on a marker, then async reset
        do_reset();
        err_seen = 0;
        for (int c = 0; c < 50; c++) begin
            step((c != 31), (c % 4 == 3) || (c == 9), 39'($urandom));
            if (a_e) err_seen++;
            if (c == 15) chk("t4_no_early_lock", a_l, 0);
            if (c == 26) chk("t4_not_yet_locked", a_l, 0);
            if (c == 27) chk("t4_relocked", a_l, 1);
            if (c == 31) begin
                chk("t5_dis_locked", a_l, 0);
                chk("t5_dis_vld", a_v, 0);
            end
            if (c == 49) chk("t5_pre_rst_locked", a_l, 1);
        end
        chk("t4_no_align_err", 160'(err_seen), 0);
        rstn = 1'b0;
        #2;
        chk("t5_rst_locked", bus4.locked, 0);
        chk("t5_rst_vld", bus4.dout_vld, 0);
        chk("t5_rst_err", bus4.align_err, 0);
        chk("t5_rst_dout", bus4.dout, 0);
        #1;
        rstn = 1'b1;
        model_reset();

        // RATIO=1: marker on every word, one dropped
        sel = 1;
        m_ratio = 1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, (c != 6), 39'($urandom));
            if (c == 2) chk("t6_not_locked", a_l, 0);
            if (c == 3) begin
                chk("t6_locked", a_l, 1);
                chk("t6_no_vld_yet", a_v, 0);
            end
            if (c >= 4) chk("t6_vld_every_clk", a_v, 1);
            if (c == 6) chk("t6_still_locked", a_l, 1);
        end

        // Randomized marker streams against the model, both instances
        for (int s = 0; s < 2; s++) begin
            int tx_ph;
            sel = s;
            m_ratio = (s == 0) ? 4 : 1;
            do_reset();
            tx_ph = $urandom_range(0, m_ratio - 1);
            for (int k = 0; k < 400; k++) begin
                bit en;
                bit mk;
                int r;
                r  = $urandom_range(0, 99);
                en = (r >= 2);
                tx_ph = (tx_ph + 1) % m_ratio;
                mk = (tx_ph == m_ratio - 1);
                r  = $urandom_range(0, 99);
                if (r < 6)      mk = !mk;
                else if (r < 8) tx_ph = (tx_ph + 1) % m_ratio;
                step(en, mk, 39'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
